// File: rtl/apb_reg_bank.sv
// APB slave register bank: NREGS byte-strobed control registers, a live status word,
// a W1C interrupt flag register with enable mask, and programmable wait states.
module apb_reg_bank #(
    parameter int DWIDTH      = 32,
    parameter int NREGS       = 4,
    parameter int AWIDTH      = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [AWIDTH-1:0]       PADDR,
    input  logic [DWIDTH-1:0]       PWDATA,
    input  logic [DWIDTH/8-1:0]     PSTRB,
    output logic [DWIDTH-1:0]       PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic [DWIDTH-1:0]       status_in,
    input  logic [DWIDTH-1:0]       irq_set,
    output logic [NREGS*DWIDTH-1:0] regs_out,
    output logic                    irq
);

    localparam int NBYTES     = DWIDTH / 8;
    localparam int CW         = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int IDX_STATUS = NREGS;
    localparam int IDX_IFLAG  = NREGS + 1;
    localparam int IDX_IEN    = NREGS + 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_STATES);

    logic [CW-1:0]                 cnt;
    logic [NREGS-1:0][DWIDTH-1:0]  ctrl_q;
    logic [DWIDTH-1:0]             iflag_q;
    logic [DWIDTH-1:0]             ien_q;

    logic              access;
    logic              cnt_done;
    logic              unmapped;
    logic              is_ctrl;
    logic              is_status;
    logic              commit;
    int                addr_idx;
    logic [DWIDTH-1:0] byte_mask;
    logic [DWIDTH-1:0] wr_bits;
    logic [DWIDTH-1:0] iflag_clr;
    logic [DWIDTH-1:0] rd_mux;

    assign access    = PSEL & PENABLE;
    assign cnt_done  = (cnt == CNT_LAST);
    assign addr_idx  = int'(PADDR);
    assign is_ctrl   = (addr_idx < NREGS);
    assign is_status = (addr_idx == IDX_STATUS);
    assign unmapped  = (addr_idx > IDX_IEN);

    // PRESETn gating keeps PREADY quiet while reset is held even with zero wait states.
    assign PREADY  = PRESETn & access & cnt_done;
    assign PSLVERR = PREADY & (unmapped | (PWRITE & is_status));
    assign commit  = PREADY & PWRITE & ~PSLVERR;

    always_comb begin
        byte_mask = '0;
        for (int k = 0; k < NBYTES; k++) begin
            byte_mask[k*8 +: 8] = {8{PSTRB[k]}};
        end
    end

    assign wr_bits   = PWDATA & byte_mask;
    assign iflag_clr = (commit && addr_idx == IDX_IFLAG) ? wr_bits : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt <= '0;
        end else if (!access || cnt_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (commit && addr_idx == i) begin
                    ctrl_q[i] <= (ctrl_q[i] & ~byte_mask) | wr_bits;
                end
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ien_q <= '0;
        end else if (commit && addr_idx == IDX_IEN) begin
            ien_q <= (ien_q & ~byte_mask) | wr_bits;
        end
    end

    // New events are OR-ed in after the clear so a same-cycle set always survives.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            iflag_q <= '0;
        end else begin
            iflag_q <= (iflag_q & ~iflag_clr) | irq_set;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (is_ctrl) begin
            for (int i = 0; i < NREGS; i++) begin
                if (addr_idx == i) begin
                    rd_mux = ctrl_q[i];
                end
            end
        end else if (is_status) begin
            rd_mux = status_in;
        end else if (addr_idx == IDX_IFLAG) begin
            rd_mux = iflag_q;
        end else if (addr_idx == IDX_IEN) begin
            rd_mux = ien_q;
        end
    end

    assign PRDATA   = (PREADY & ~PWRITE & ~PSLVERR) ? rd_mux : '0;
    assign regs_out = ctrl_q;
    assign irq      = |(iflag_q & ien_q);

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench for apb_reg_bank with two wait states: latency, strobes, status,
// errors, interrupt flags, set-beats-clear, aborted transfers and mid-access reset.
module tb_apb_reg_bank;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int AW = 4;
    localparam int WS = 2;

    logic             PCLK = 1'b0;
    logic             PRESETn;
    logic             PSEL, PENABLE, PWRITE;
    logic [AW-1:0]    PADDR;
    logic [DW-1:0]    PWDATA;
    logic [DW/8-1:0]  PSTRB;
    logic [DW-1:0]    PRDATA;
    logic             PREADY, PSLVERR;
    logic [DW-1:0]    status_in, irq_set;
    logic [NR*DW-1:0] regs_out;
    logic             irq;

    int errors = 0;
    int checks = 0;

    logic [NR*DW-1:0] exp_regs;
    logic [31:0]      rd;
    logic             er;
    int               lat;

    apb_reg_bank #(.DWIDTH(DW), .NREGS(NR), .AWIDTH(AW), .WAIT_STATES(WS)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .status_in(status_in), .irq_set(irq_set), .regs_out(regs_out), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // One full APB transfer; irq_at_ready is driven on irq_set during the PREADY cycle.
    task automatic applyStimulus(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input logic [31:0] irq_at_ready,
                                 output logic [31:0] rdata, output logic err, output int latency);
        bit done;
        done = 0;
        rdata = '0;
        err = 1'b0;
        latency = 0;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int c = 1; c <= 10 && !done; c++) begin
            @(negedge PCLK);
            if (PREADY) begin
                done = 1;
                latency = c;
                rdata = PRDATA;
                err = PSLVERR;
                irq_set = irq_at_ready;
            end
            @(posedge PCLK); #1;
            irq_set = '0;
        end
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        if (!done) checkOutput("pready_timeout", 128'd0, 128'd1);
    endtask

    task automatic doWrite(input string tag, input logic [3:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic exp_err, input logic [31:0] irq_at_ready);
        applyStimulus(1'b1, addr, wdata, strb, irq_at_ready, rd, er, lat);
        checkOutput({tag, "_lat"}, 128'(lat), 128'(WS + 1));
        checkOutput({tag, "_err"}, 128'(er), 128'(exp_err));
    endtask

    task automatic doRead(input string tag, input logic [3:0] addr,
                          input logic [31:0] exp_data, input logic exp_err);
        applyStimulus(1'b0, addr, '0, 4'h0, '0, rd, er, lat);
        checkOutput({tag, "_lat"}, 128'(lat), 128'(WS + 1));
        checkOutput({tag, "_data"}, 128'(rd), 128'(exp_data));
        checkOutput({tag, "_err"}, 128'(er), 128'(exp_err));
    endtask

    initial begin
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; status_in = '0; irq_set = '0;
        exp_regs = '0;
        #2;
        checkOutput("init_regs", 128'(regs_out), 128'd0);
        checkOutput("init_irq", 128'(irq), 128'd0);
        checkOutput("init_pready", 128'(PREADY), 128'd0);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK) PRESETn = 1'b1;

        // Byte strobes 0101 keep only bytes 0 and 2 of DEADBEEF.
        doWrite("ctrl2_wr", 4'd2, 32'hDEADBEEF, 4'b0101, 1'b0, '0);
        exp_regs[95:64] = 32'h00AD00EF;
        checkOutput("ctrl2_regs", 128'(regs_out), 128'(exp_regs));
        doRead("ctrl2_rd", 4'd2, 32'h00AD00EF, 1'b0);

        status_in = 32'h12345678;
        doRead("status_rd", 4'd4, 32'h12345678, 1'b0);
        doWrite("status_wr", 4'd4, 32'hFFFFFFFF, 4'hF, 1'b1, '0);
        checkOutput("status_wr_regs", 128'(regs_out), 128'(exp_regs));
        doRead("unmapped_rd", 4'd9, 32'h0, 1'b1);
        doWrite("unmapped_wr", 4'd7, 32'hFFFFFFFF, 4'hF, 1'b1, '0);
        checkOutput("unmapped_wr_regs", 128'(regs_out), 128'(exp_regs));

        doWrite("ien_wr", 4'd6, 32'h00000001, 4'hF, 1'b0, '0);
        checkOutput("irq_before_set", 128'(irq), 128'd0);
        @(posedge PCLK); #1 irq_set = 32'h3;
        @(posedge PCLK); #1 irq_set = 32'h0;
        @(negedge PCLK);
        checkOutput("irq_after_set", 128'(irq), 128'd1);
        doRead("iflag_rd1", 4'd5, 32'h3, 1'b0);
        doWrite("iflag_w1c", 4'd5, 32'h1, 4'hF, 1'b0, '0);
        @(negedge PCLK);
        checkOutput("irq_after_clr", 128'(irq), 128'd0);
        doRead("iflag_rd2", 4'd5, 32'h2, 1'b0);
        doRead("ien_rd", 4'd6, 32'h1, 1'b0);

        doWrite("set_beats_clr", 4'd5, 32'h2, 4'hF, 1'b0, 32'h2);
        doRead("iflag_rd3", 4'd5, 32'h2, 1'b0);
        // A W1C with its byte strobe off must not clear.
        doWrite("w1c_nostrb", 4'd5, 32'h2, 4'b1110, 1'b0, '0);
        doRead("iflag_rd4", 4'd5, 32'h2, 1'b0);

        doWrite("ctrl0_wr", 4'd0, 32'h11223344, 4'hF, 1'b0, '0);
        exp_regs[31:0] = 32'h11223344;
        checkOutput("ctrl0_regs", 128'(regs_out), 128'(exp_regs));

        // Abort: PSEL drops after one wait cycle.
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd0; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(negedge PCLK);
        checkOutput("abort_pready1", 128'(PREADY), 128'd0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        checkOutput("abort_pready2", 128'(PREADY), 128'd0);
        checkOutput("abort_regs", 128'(regs_out), 128'(exp_regs));
        doRead("after_abort_rd", 4'd0, 32'h11223344, 1'b0);

        @(posedge PCLK); #1 irq_set = 32'h1;
        @(posedge PCLK); #1 irq_set = 32'h0;
        @(negedge PCLK);
        checkOutput("irq_pre_reset", 128'(irq), 128'd1);

        // Reset mid-wait of a write to CTRL[1].
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd1; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1 PRESETn = 1'b0;
        #2;
        checkOutput("rst_regs", 128'(regs_out), 128'd0);
        checkOutput("rst_irq", 128'(irq), 128'd0);
        checkOutput("rst_pready", 128'(PREADY), 128'd0);
        checkOutput("rst_prdata", 128'(PRDATA), 128'd0);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(negedge PCLK) PRESETn = 1'b1;
        exp_regs = '0;

        status_in = 32'h0;
        for (int a = 0; a <= 6; a++) begin
            doRead($sformatf("post_rst_rd%0d", a), 4'(a), 32'h0, 1'b0);
        end
        checkOutput("post_rst_regs", 128'(regs_out), 128'(exp_regs));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
